// File: rtl/cci_test_csr_pkg.sv
// Shared types and header address map for the CCI test CSR MMIO front end.
package cci_test_csr_pkg;

   localparam int NUM_TEST_CSRS = 8;
   localparam int IDX_W         = $clog2(NUM_TEST_CSRS);

   // Byte addresses of the fixed header words (18 bits = 16-bit dword address * 4)
   localparam logic [17:0] DFH_BYTE      = 18'h000;
   localparam logic [17:0] AFU_ID_L_BYTE = 18'h008;
   localparam logic [17:0] AFU_ID_H_BYTE = 18'h010;
   localparam logic [17:0] RSVD0_BYTE    = 18'h018;
   localparam logic [17:0] RSVD1_BYTE    = 18'h020;

   typedef logic [15:0] t_mmio_dw_addr;
   typedef logic [8:0]  t_mmio_tid;
   typedef logic [IDX_W-1:0] t_csr_idx;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_DFH,
      SEL_IDL,
      SEL_IDH,
      SEL_CYC,
      SEL_TEST
   } t_csr_sel;

   typedef struct packed {
      logic [63:0] data;
   } t_cpu_rd_csr;

   typedef struct packed {
      logic        en;
      logic [63:0] data;
   } t_cpu_wr_csr;

endpackage

// File: rtl/test_csrs.sv
// CSR exchange between the MMIO front end (csr modport) and the test engine (test modport).
interface test_csrs;
   cci_test_csr_pkg::t_cpu_rd_csr cpu_rd_csrs [cci_test_csr_pkg::NUM_TEST_CSRS];
   cci_test_csr_pkg::t_cpu_wr_csr cpu_wr_csrs [cci_test_csr_pkg::NUM_TEST_CSRS];

   modport csr  (input cpu_rd_csrs, output cpu_wr_csrs);
   modport test (output cpu_rd_csrs, input cpu_wr_csrs);
endinterface

// File: rtl/cci_test_csr_rd_pipe.sv
// Two-stage MMIO read pipeline: stage1 registers tid/select/index, stage2 muxes and registers data.
module cci_test_csr_rd_pipe
   import cci_test_csr_pkg::*;
#(
   parameter logic [63:0]  DFH_VALUE = 64'h1000_0000_0000_0000,
   parameter logic [127:0] AFU_ID    = 128'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd_valid_i,
   input  t_mmio_tid   tid_i,
   input  t_csr_sel    sel_i,
   input  t_csr_idx    idx_i,
   input  logic [63:0] cyc_cnt_i,
   input  t_cpu_rd_csr rd_csrs_i [NUM_TEST_CSRS],
   output logic        rsp_valid_o,
   output t_mmio_tid   rsp_tid_o,
   output logic [63:0] rsp_data_o
);

   logic        vld_p1_q;
   t_mmio_tid   tid_p1_q;
   t_csr_sel    sel_p1_q;
   t_csr_idx    idx_p1_q;
   logic [63:0] cyc_p1_q;

   logic        rsp_valid_q;
   t_mmio_tid   rsp_tid_q;
   logic [63:0] rsp_data_q;
   logic [63:0] data_d;

   // Stage 1: capture request and decoded select; the cycle count is sampled here
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1_q <= 1'b0;
         tid_p1_q <= '0;
         sel_p1_q <= SEL_NONE;
         idx_p1_q <= '0;
         cyc_p1_q <= '0;
      end else begin
         vld_p1_q <= rd_valid_i;
         tid_p1_q <= tid_i;
         sel_p1_q <= sel_i;
         idx_p1_q <= idx_i;
         cyc_p1_q <= cyc_cnt_i;
      end
   end

   always_comb begin
      data_d = '0;
      case (sel_p1_q)
         SEL_DFH:  data_d = DFH_VALUE;
         SEL_IDL:  data_d = AFU_ID[63:0];
         SEL_IDH:  data_d = AFU_ID[127:64];
         SEL_CYC:  data_d = cyc_p1_q;
         SEL_TEST: data_d = rd_csrs_i[idx_p1_q].data;
         default:  data_d = '0;
      endcase
   end

   // Stage 2: register the response
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_tid_q   <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= vld_p1_q;
         if (vld_p1_q) begin
            rsp_tid_q  <= tid_p1_q;
            rsp_data_q <= data_d;
         end
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_tid_o   = rsp_tid_q;
   assign rsp_data_o  = rsp_data_q;

endmodule

// File: rtl/cci_test_csr_mmio.sv
// MMIO front end for test AFUs: write decode into cpu_wr_csrs pulses, reads via cci_test_csr_rd_pipe.
// Optional free-running cycle counter at byte 0x020 when CCI_TEST_CSR_CYCLE_CNT_EN is defined.
module cci_test_csr_mmio
   import cci_test_csr_pkg::*;
#(
   parameter logic [63:0]  DFH_VALUE     = 64'h1000_0000_0000_0000,
   parameter logic [127:0] AFU_ID        = 128'h0,
   parameter int           CSR_BASE_BYTE = 'h100
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          mmio_wr_valid,
   input  logic          mmio_rd_valid,
   input  t_mmio_dw_addr mmio_addr,
   input  logic [1:0]    mmio_len,
   input  t_mmio_tid     mmio_tid,
   input  logic [63:0]   mmio_wr_data,
   output logic          rsp_valid,
   output t_mmio_tid     rsp_tid,
   output logic [63:0]   rsp_data,
   test_csrs.csr         csrs
);

   localparam logic [17:0] CSR_BASE = 18'(CSR_BASE_BYTE);
   localparam logic [17:0] CSR_SPAN = 18'(8 * NUM_TEST_CSRS);

   logic [17:0] byte_addr;
   logic [17:0] csr_off;
   logic        acc_ok;
   t_csr_sel    sel_d;
   t_csr_idx    idx_d;
   logic [63:0] cyc_cnt;

   t_cpu_wr_csr wr_q    [NUM_TEST_CSRS];
   t_cpu_rd_csr rd_csrs [NUM_TEST_CSRS];

   assign byte_addr = {mmio_addr, 2'b00};
   assign acc_ok    = (mmio_len == 2'd1) && !mmio_addr[0];
   assign csr_off   = byte_addr - CSR_BASE;

   // Shared full-width decode for reads and writes; unmapped or malformed accesses select nothing
   always_comb begin
      sel_d = SEL_NONE;
      idx_d = '0;
      if (acc_ok) begin
         if (byte_addr == DFH_BYTE)           sel_d = SEL_DFH;
         else if (byte_addr == AFU_ID_L_BYTE) sel_d = SEL_IDL;
         else if (byte_addr == AFU_ID_H_BYTE) sel_d = SEL_IDH;
`ifdef CCI_TEST_CSR_CYCLE_CNT_EN
         else if (byte_addr == RSVD1_BYTE)    sel_d = SEL_CYC;
`endif
         else if (byte_addr >= CSR_BASE && csr_off < CSR_SPAN) begin
            sel_d = SEL_TEST;
            idx_d = csr_off[3 +: IDX_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_TEST_CSRS; i++) begin
            wr_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_TEST_CSRS; i++) begin
            wr_q[i].en <= mmio_wr_valid && (sel_d == SEL_TEST) && (idx_d == t_csr_idx'(i));
            if (mmio_wr_valid && (sel_d == SEL_TEST) && (idx_d == t_csr_idx'(i))) begin
               wr_q[i].data <= mmio_wr_data;
            end
         end
      end
   end

`ifdef CCI_TEST_CSR_CYCLE_CNT_EN
   logic [63:0] cyc_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_q <= '0;
      end else if (mmio_wr_valid && (sel_d == SEL_CYC)) begin
         cyc_q <= '0;
      end else begin
         cyc_q <= cyc_q + 64'd1;
      end
   end

   assign cyc_cnt = cyc_q;
`else
   assign cyc_cnt = '0;
`endif

   for (genvar g = 0; g < NUM_TEST_CSRS; g++) begin : g_csr
      assign csrs.cpu_wr_csrs[g] = wr_q[g];
      assign rd_csrs[g]          = csrs.cpu_rd_csrs[g];
   end

   cci_test_csr_rd_pipe #(
      .DFH_VALUE (DFH_VALUE),
      .AFU_ID    (AFU_ID)
   ) u_rd_pipe (
      .clk         (clk),
      .reset       (reset),
      .rd_valid_i  (mmio_rd_valid),
      .tid_i       (mmio_tid),
      .sel_i       (sel_d),
      .idx_i       (idx_d),
      .cyc_cnt_i   (cyc_cnt),
      .rd_csrs_i   (rd_csrs),
      .rsp_valid_o (rsp_valid),
      .rsp_tid_o   (rsp_tid),
      .rsp_data_o  (rsp_data)
   );

endmodule

// File: tb/tb_cci_test_csr_mmio.sv
// Directed self-checking bench for cci_test_csr_mmio (honours CCI_TEST_CSR_CYCLE_CNT_EN).
module tb_cci_test_csr_mmio;
   import cci_test_csr_pkg::*;

   localparam logic [63:0]  DFH_V    = 64'h1000_0000_0000_0000;
   localparam logic [127:0] AFU_V    = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
   localparam int           CSR_BASE = 'h100;

   logic          clk = 1'b0;
   logic          reset;
   logic          mmio_wr_valid;
   logic          mmio_rd_valid;
   t_mmio_dw_addr mmio_addr;
   logic [1:0]    mmio_len;
   t_mmio_tid     mmio_tid;
   logic [63:0]   mmio_wr_data;
   logic          rsp_valid;
   t_mmio_tid     rsp_tid;
   logic [63:0]   rsp_data;

   int checks = 0;
   int errors = 0;

   test_csrs csrs_if ();

   cci_test_csr_mmio #(
      .DFH_VALUE     (DFH_V),
      .AFU_ID        (AFU_V),
      .CSR_BASE_BYTE (CSR_BASE)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .mmio_wr_valid (mmio_wr_valid),
      .mmio_rd_valid (mmio_rd_valid),
      .mmio_addr     (mmio_addr),
      .mmio_len      (mmio_len),
      .mmio_tid      (mmio_tid),
      .mmio_wr_data  (mmio_wr_data),
      .rsp_valid     (rsp_valid),
      .rsp_tid       (rsp_tid),
      .rsp_data      (rsp_data),
      .csrs          (csrs_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NUM_TEST_CSRS-1:0] en_vec();
      logic [NUM_TEST_CSRS-1:0] v;
      for (int i = 0; i < NUM_TEST_CSRS; i++) v[i] = csrs_if.cpu_wr_csrs[i].en;
      return v;
   endfunction

   function automatic t_mmio_dw_addr csr_dw(input int i);
      return t_mmio_dw_addr'((CSR_BASE + 8 * i) / 4);
   endfunction

   task automatic drive_idle();
      mmio_wr_valid = 1'b0;
      mmio_rd_valid = 1'b0;
      mmio_addr     = '0;
      mmio_len      = 2'd1;
      mmio_tid      = '0;
      mmio_wr_data  = '0;
   endtask

   task automatic drive_wr(input t_mmio_dw_addr a, input logic [1:0] l, input logic [63:0] d);
      mmio_wr_valid = 1'b1;
      mmio_rd_valid = 1'b0;
      mmio_addr     = a;
      mmio_len      = l;
      mmio_wr_data  = d;
   endtask

   task automatic drive_rd(input t_mmio_dw_addr a, input logic [1:0] l, input t_mmio_tid t);
      mmio_wr_valid = 1'b0;
      mmio_rd_valid = 1'b1;
      mmio_addr     = a;
      mmio_len      = l;
      mmio_tid      = t;
   endtask

   // Single write: one-cycle pulse on the expected entry (or none), then quiet
   task automatic wr_pulse(input string tag, input t_mmio_dw_addr a, input logic [1:0] l,
                           input logic [63:0] d, input logic [NUM_TEST_CSRS-1:0] exp_en);
      drive_wr(a, l, d);
      tick();
      chk({tag, "_en"}, 64'(en_vec()), 64'(exp_en));
      for (int i = 0; i < NUM_TEST_CSRS; i++)
         if (exp_en[i]) chk({tag, "_data"}, csrs_if.cpu_wr_csrs[i].data, d);
      drive_idle();
      tick();
      chk({tag, "_drop"}, 64'(en_vec()), 64'd0);
   endtask

   // Single isolated read: nothing at +1, response at +2
   task automatic rd_expect(input string tag, input t_mmio_dw_addr a, input logic [1:0] l,
                            input t_mmio_tid t, input logic [63:0] exp);
      drive_rd(a, l, t);
      tick();
      chk({tag, "_early"}, 64'(rsp_valid), 64'd0);
      drive_idle();
      tick();
      chk({tag, "_vld"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_tid"}, 64'(rsp_tid), 64'(t));
      chk({tag, "_data"}, rsp_data, exp);
   endtask

   task automatic rd_get(input t_mmio_dw_addr a, input t_mmio_tid t, output logic [63:0] v);
      drive_rd(a, 2'd1, t);
      tick();
      drive_idle();
      tick();
      chk("rdget_vld", 64'(rsp_valid), 64'd1);
      v = rsp_data;
   endtask

   initial begin
      int viol;
      logic [63:0] v0, v1;

      drive_idle();
      for (int i = 0; i < NUM_TEST_CSRS; i++)
         csrs_if.cpu_rd_csrs[i].data = 64'h1111_0000 * 64'(i + 1);
      reset = 1'b1;
      tick();
      tick();

      // 1: reset state and idle
      chk("rst_rsp_vld", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_tid", 64'(rsp_tid), 64'd0);
      chk("rst_rsp_data", rsp_data, 64'd0);
      chk("rst_en", 64'(en_vec()), 64'd0);
      v0 = '0;
      for (int i = 0; i < NUM_TEST_CSRS; i++) v0 |= csrs_if.cpu_wr_csrs[i].data;
      chk("rst_wr_data", v0, 64'd0);
      reset = 1'b0;
      viol = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (rsp_valid !== 1'b0 || en_vec() !== '0) viol++;
      end
      chk("idle10", 64'(viol), 64'd0);

      // 2: writes
      wr_pulse("wr3", csr_dw(3), 2'd1, 64'hDEAD_BEEF_0123_4567, 8'b0000_1000);
      chk("wr3_hold", csrs_if.cpu_wr_csrs[3].data, 64'hDEAD_BEEF_0123_4567);
      wr_pulse("wr7", csr_dw(7), 2'd1, 64'h7777_0000_0000_0007, 8'b1000_0000);
      wr_pulse("wr_len4", csr_dw(2), 2'd0, 64'h1, 8'b0);
      wr_pulse("wr_odd", csr_dw(2) + 16'd1, 2'd1, 64'h2, 8'b0);
      wr_pulse("wr_dfh", 16'h0000, 2'd1, 64'h3, 8'b0);
      wr_pulse("wr_idx8", csr_dw(8), 2'd1, 64'h4, 8'b0);
      wr_pulse("wr_800", 16'h0200, 2'd1, 64'h5, 8'b0);
      // back-to-back to the same entry: two pulses
      drive_wr(csr_dw(2), 2'd1, 64'hAAAA);
      tick();
      chk("b2b_en1", 64'(en_vec()), 64'h4);
      chk("b2b_d1", csrs_if.cpu_wr_csrs[2].data, 64'hAAAA);
      drive_wr(csr_dw(2), 2'd1, 64'hBBBB);
      tick();
      chk("b2b_en2", 64'(en_vec()), 64'h4);
      chk("b2b_d2", csrs_if.cpu_wr_csrs[2].data, 64'hBBBB);
      drive_idle();
      tick();
      chk("b2b_drop", 64'(en_vec()), 64'd0);

      // 3: pipelined reads
      csrs_if.cpu_rd_csrs[7].data = 64'hA5A5;
      drive_rd(csr_dw(7), 2'd1, 9'd5);
      tick();
      chk("p_early", 64'(rsp_valid), 64'd0);
      drive_rd(16'h0002, 2'd1, 9'd6);
      tick();
      chk("p5_vld", 64'(rsp_valid), 64'd1);
      chk("p5_tid", 64'(rsp_tid), 64'd5);
      chk("p5_data", rsp_data, 64'hA5A5);
      drive_rd(16'h0001, 2'd0, 9'd7);
      tick();
      chk("p6_vld", 64'(rsp_valid), 64'd1);
      chk("p6_tid", 64'(rsp_tid), 64'd6);
      chk("p6_data", rsp_data, AFU_V[63:0]);
      drive_idle();
      tick();
      chk("p7_vld", 64'(rsp_valid), 64'd1);
      chk("p7_tid", 64'(rsp_tid), 64'd7);
      chk("p7_data", rsp_data, 64'd0);
      tick();
      chk("p_end", 64'(rsp_valid), 64'd0);

      rd_expect("rd_dfh", 16'h0000, 2'd1, 9'd1, DFH_V);
      rd_expect("rd_idh", 16'h0004, 2'd1, 9'd2, AFU_V[127:64]);
      rd_expect("rd_rsv", 16'h0006, 2'd1, 9'd3, 64'd0);
      rd_expect("rd_csr0", csr_dw(0), 2'd1, 9'd4, 64'h1111_0000);
      rd_expect("rd_csr3", csr_dw(3), 2'd1, 9'd8, 64'h4444_0000);

      // rd_csrs value is taken the cycle after the request
      drive_rd(csr_dw(4), 2'd1, 9'd20);
      tick();
      csrs_if.cpu_rd_csrs[4].data = 64'hC0FFEE;
      drive_idle();
      tick();
      chk("rd_samp_data", rsp_data, 64'hC0FFEE);

      // 4: unmapped
      rd_expect("rd_800", 16'h0200, 2'd1, 9'h1FF, 64'd0);
      rd_expect("rd_idx8", csr_dw(8), 2'd1, 9'd9, 64'd0);

      // 5: reset mid-flight
      drive_rd(csr_dw(7), 2'd1, 9'd10);
      tick();
      drive_rd(csr_dw(7), 2'd1, 9'd11);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive_idle();
      viol = 0;
      for (int c = 0; c < 4; c++) begin
         if (rsp_valid !== 1'b0) viol++;
         tick();
      end
      chk("rst_flight", 64'(viol), 64'd0);
      rd_expect("rd_after_rst", csr_dw(7), 2'd1, 9'd12, 64'hA5A5);
      drive_wr(csr_dw(1), 2'd1, 64'h99);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive_idle();
      chk("rst_wr_supp", 64'(en_vec()), 64'd0);
      tick();

      // 6: cycle counter
`ifdef CCI_TEST_CSR_CYCLE_CNT_EN
      rd_get(16'h0008, 9'd30, v0);
      for (int c = 0; c < 98; c++) tick();
      rd_get(16'h0008, 9'd31, v1);
      chk("cyc_delta", v1 - v0, 64'd100);
      wr_pulse("wr_cyc", 16'h0008, 2'd1, 64'hFFFF, 8'b0);
      tick();
      tick();
      tick();
      rd_get(16'h0008, 9'd32, v0);
      chk("cyc_clr", 64'(v0 < 64'd8), 64'd1);
`else
      wr_pulse("wr_cyc", 16'h0008, 2'd1, 64'hFFFF, 8'b0);
      rd_get(16'h0008, 9'd30, v0);
      chk("cyc_off", v0, 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
